// File: rtl/nicnac16_pkg.sv
// Shared types and constants for the NICNAC16 memory arbiter slice.
// Requester IDs double as the owner / last-grant encoding.
package nicnac16_pkg;

    localparam int DEF_AW = 12;
    localparam int DEF_DW = 16;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RWAIT  = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/nicnac16_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: a lone requester wins,
// a tie goes to whoever was not granted last.
module rr_arb2
    import nicnac16_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic       gnt_vld_o,
    output logic       gnt_id_o
);

    always_comb begin
        gnt_vld_o = |req_i;
        if (&req_i) begin
            gnt_id_o = ~last_gnt_i;
        end else if (req_i[REQ_LDR]) begin
            gnt_id_o = REQ_LDR;
        end else begin
            gnt_id_o = REQ_CPU;
        end
    end

endmodule

// File: rtl/nicnac16_mem_arbiter.sv
// CPU / loader arbiter and sequencer for the single-port main RAM.
// Write acks 2 cycles after the sampling IDLE cycle, reads 3; every output is registered.
module nicnac16_mem_arbiter
    import nicnac16_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic          cpu_ack_o,
    output logic [DW-1:0] cpu_rdata_o,
    input  logic          ldr_req_i,
    input  logic          ldr_we_i,
    input  logic [AW-1:0] ldr_addr_i,
    input  logic [DW-1:0] ldr_wdata_i,
    output logic          ldr_ack_o,
    output logic [DW-1:0] ldr_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          owner_ldr_o
);

    state_e        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic          owner_q, owner_d;
    logic          we_q, we_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ldr_ack_q, ldr_ack_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ldr_rdata_q, ldr_rdata_d;
    logic          gnt_vld;
    logic          gnt_id;

    rr_arb2 u_arb (
        .req_i      ({ldr_req_i, cpu_req_i}),
        .last_gnt_i (last_gnt_q),
        .gnt_vld_o  (gnt_vld),
        .gnt_id_o   (gnt_id)
    );

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;

        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d    = gnt_id;
                    last_gnt_d = gnt_id;
                    mem_en_d   = 1'b1;
                    state_d    = ACCESS;
                    if (gnt_id == REQ_LDR) begin
                        we_d        = ldr_we_i;
                        mem_we_d    = ldr_we_i;
                        mem_addr_d  = ldr_addr_i;
                        mem_wdata_d = ldr_wdata_i;
                    end else begin
                        we_d        = cpu_we_i;
                        mem_we_d    = cpu_we_i;
                        mem_addr_d  = cpu_addr_i;
                        mem_wdata_d = cpu_wdata_i;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    cpu_ack_d = (owner_q == REQ_CPU);
                    ldr_ack_d = (owner_q == REQ_LDR);
                    state_d   = DONE;
                end else begin
                    state_d   = RWAIT;
                end
            end
            RWAIT: begin
                // RAM data belongs to the ACCESS cycle just past
                if (owner_q == REQ_LDR) begin
                    ldr_rdata_d = mem_rdata_i;
                    ldr_ack_d   = 1'b1;
                end else begin
                    cpu_rdata_d = mem_rdata_i;
                    cpu_ack_d   = 1'b1;
                end
                state_d = DONE;
            end
            DONE: begin
                owner_d = REQ_CPU;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            last_gnt_q  <= REQ_LDR;
            owner_q     <= REQ_CPU;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    assign cpu_ack_o   = cpu_ack_q;
    assign ldr_ack_o   = ldr_ack_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign ldr_rdata_o = ldr_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign owner_ldr_o = owner_q;

endmodule

// File: tb/tb_nicnac16_mem_arbiter.sv
// Bench for nicnac16_mem_arbiter: directed scenarios plus a randomized
// two-requester run checked against a transaction-level model.
module tb_nicnac16_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          ldr_req = 1'b0, ldr_we = 1'b0;
    logic [AW-1:0] ldr_addr = '0;
    logic [DW-1:0] ldr_wdata = '0;
    logic          ldr_ack;
    logic [DW-1:0] ldr_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          owner_ldr;

    int checks = 0;
    int failures = 0;

    // expectation model: memory contents, last winner, held read data
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          exp_last_ldr;
    logic [DW-1:0] exp_cpu_rd, exp_ldr_rd;

    logic [DW-1:0] ram [0:(1<<AW)-1];

    nicnac16_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata),
        .ldr_req_i(ldr_req), .ldr_we_i(ldr_we), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
        .ldr_ack_o(ldr_ack), .ldr_rdata_o(ldr_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .owner_ldr_o(owner_ldr)
    );

    always #10 clk = ~clk;

    // one-cycle-latency synchronous RAM
    initial begin
        for (int i = 0; i < (1<<AW); i++) ram[i] = 16'(i * 7 + 3);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) ram[mem_addr] <= mem_wdata;
                else        mem_rdata <= ram[mem_addr];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        exp_last_ldr = 1'b1;
        exp_cpu_rd   = '0;
        exp_ldr_rd   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cpu_req = 1'b0; ldr_req = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        int grants;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h555; cpu_wdata = 16'h5555;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, cpu_ack, ldr_ack, owner_ldr} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b exp 00000", {mem_en, mem_we, cpu_ack, ldr_ack, owner_ldr});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== '0) begin
            failures++; $display("FAIL reset_mem_bus: got addr %h data %h exp 0", mem_addr, mem_wdata);
        end
        checks++;
        if ({cpu_rdata, ldr_rdata} !== '0) begin
            failures++; $display("FAIL reset_rdata: got %h/%h exp 0", cpu_rdata, ldr_rdata);
        end
        grants = 0;
        repeat (3) begin @(negedge clk); grants += int'(mem_en); end
        checks++;
        if (grants != 0) begin
            failures++; $display("FAIL reset_no_grant: got %0d mem_en cycles exp 0", grants);
        end
        cpu_req = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_cpu_write();
        int extra;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 16'hBEEF;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 12'h123, 16'hBEEF}) begin
            failures++; $display("FAIL wr_access: got en%b we%b %h=%h exp en1 we1 123=beef", mem_en, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        checks++;
        if ({cpu_ack, ldr_ack} !== 2'b10) begin
            failures++; $display("FAIL wr_ack_c2: got cpu%b ldr%b exp cpu1 ldr0", cpu_ack, ldr_ack);
        end
        cpu_req = 1'b0;
        ref_mem[12'h123] = 16'hBEEF;
        exp_last_ldr = 1'b0;
        extra = 0;
        repeat (4) begin @(negedge clk); extra += int'(cpu_ack) + int'(ldr_ack) + int'(mem_en); end
        checks++;
        if (extra != 0) begin
            failures++; $display("FAIL wr_single: got %0d extra ack/en cycles exp 0", extra);
        end
    endtask

    task automatic test_cpu_read();
        int extra;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 12'h123}) begin
            failures++; $display("FAIL rd_access: got en%b we%b %h exp en1 we0 123", mem_en, mem_we, mem_addr);
        end
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0) begin
            failures++; $display("FAIL rd_early_ack: got %b exp 0", cpu_ack);
        end
        @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, ref_mem[12'h123]}) begin
            failures++; $display("FAIL rd_ack_c3: got ack%b %h exp ack1 %h", cpu_ack, cpu_rdata, ref_mem[12'h123]);
        end
        cpu_req = 1'b0;
        exp_cpu_rd = ref_mem[12'h123];
        exp_last_ldr = 1'b0;
        extra = 0;
        repeat (10) begin @(negedge clk); extra += int'(cpu_ack) + int'(mem_en); end
        checks++;
        if (cpu_rdata !== exp_cpu_rd || extra != 0) begin
            failures++; $display("FAIL rd_hold: got %h (%0d extra) exp %h (0 extra)", cpu_rdata, extra, exp_cpu_rd);
        end
    endtask

    task automatic test_contention();
        int waited;
        logic who;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 12'h020;
        for (int k = 0; k < 6; k++) begin
            waited = 0;
            do begin @(negedge clk); waited++; end
            while (!(cpu_ack || ldr_ack) && waited < 8);
            who = ldr_ack;
            checks++;
            if (waited >= 8 || {ldr_ack, cpu_ack} !== ((k % 2) ? 2'b10 : 2'b01)) begin
                failures++; $display("FAIL contend_grant%0d: got ldr%b cpu%b after %0d exp %s", k, ldr_ack, cpu_ack, waited, (k % 2) ? "L" : "C");
            end
            exp_last_ldr = who;
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        exp_cpu_rd = ref_mem[12'h010];
        exp_ldr_rd = ref_mem[12'h020];
        checks++;
        if ({cpu_rdata, ldr_rdata} !== {exp_cpu_rd, exp_ldr_rd}) begin
            failures++; $display("FAIL contend_rdata: got %h/%h exp %h/%h", cpu_rdata, ldr_rdata, exp_cpu_rd, exp_ldr_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_ldr_first();
        int waited;
        // a lone CPU write makes the CPU the last winner
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'hFFF; cpu_wdata = 16'hAAAA;
        waited = 0;
        do begin @(negedge clk); waited++; end while (!cpu_ack && waited < 8);
        cpu_req = 1'b0;
        ref_mem[12'hFFF] = 16'hAAAA;
        exp_last_ldr = 1'b0;
        @(negedge clk);
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 12'hFFF; ldr_wdata = 16'h1234;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'hFFF;
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, owner_ldr} !== {2'b11, 12'hFFF, 16'h1234, 1'b1}) begin
            failures++; $display("FAIL lfirst_access: got en%b we%b %h=%h own%b exp en1 we1 fff=1234 own1", mem_en, mem_we, mem_addr, mem_wdata, owner_ldr);
        end
        @(negedge clk);
        checks++;
        if ({ldr_ack, cpu_ack, owner_ldr} !== 3'b101) begin
            failures++; $display("FAIL lfirst_ack: got ldr%b cpu%b own%b exp 1 0 1", ldr_ack, cpu_ack, owner_ldr);
        end
        ldr_req = 1'b0;
        ref_mem[12'hFFF] = 16'h1234;
        @(negedge clk);
        checks++;
        if ({owner_ldr, mem_en} !== 2'b00) begin
            failures++; $display("FAIL lfirst_idle: got own%b en%b exp 0 0", owner_ldr, mem_en);
        end
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, mem_addr, owner_ldr} !== {2'b10, 12'hFFF, 1'b0}) begin
            failures++; $display("FAIL lfirst_cpu_access: got en%b we%b %h own%b exp en1 we0 fff own0", mem_en, mem_we, mem_addr, owner_ldr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdata, ldr_rdata} !== {1'b1, 16'h1234, exp_ldr_rd}) begin
            failures++; $display("FAIL lfirst_cpu_read: got ack%b %h ldr %h exp ack1 1234 ldr %h", cpu_ack, cpu_rdata, ldr_rdata, exp_ldr_rd);
        end
        cpu_req = 1'b0;
        exp_cpu_rd = 16'h1234;
        exp_last_ldr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_txn();
        int seen;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_en !== 1'b0) begin
            failures++; $display("FAIL rst_access_en: got %b exp 0", mem_en);
        end
        @(negedge clk);
        cpu_req = 1'b0; rst_n = 1'b1; model_reset();
        @(negedge clk);
        cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_we, cpu_ack, ldr_ack, owner_ldr, mem_addr, mem_wdata, cpu_rdata, ldr_rdata} !== '0) begin
            failures++; $display("FAIL rst_rwait_outs: got en%b ack%b %h %h %h exp all 0", mem_en, cpu_ack, mem_addr, cpu_rdata, ldr_rdata);
        end
        seen = 0;
        repeat (3) begin @(negedge clk); seen += int'(cpu_ack) + int'(mem_en); end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL rst_no_ack: got %0d ack/en cycles exp 0", seen);
        end
        cpu_req = 1'b0; rst_n = 1'b1; model_reset();
        @(negedge clk);
        cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, ref_mem[12'h123]}) begin
            failures++; $display("FAIL rst_fresh_read: got ack%b %h exp ack1 %h", cpu_ack, cpu_rdata, ref_mem[12'h123]);
        end
        cpu_req = 1'b0;
        exp_cpu_rd = ref_mem[12'h123];
        exp_last_ldr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_req_drop();
        int acks;
        int ens;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'hFFF;
        repeat (2) @(negedge clk);
        cpu_req = 1'b0;
        acks = 0; ens = 0;
        repeat (8) begin @(negedge clk); acks += int'(cpu_ack); ens += int'(mem_en); end
        checks++;
        if (acks != 1 || ens != 0 || cpu_rdata !== ref_mem[12'hFFF]) begin
            failures++; $display("FAIL req_drop: got %0d acks %0d en %h exp 1 acks 0 en %h", acks, ens, cpu_rdata, ref_mem[12'hFFF]);
        end
        exp_cpu_rd = ref_mem[12'hFFF];
        exp_last_ldr = 1'b0;
    endtask

    task automatic test_random();
        logic          pc, pl, first, who, t_we;
        logic          c_we, l_we;
        logic [AW-1:0] c_addr, l_addr, t_addr;
        logic [DW-1:0] c_wd, l_wd, t_wd;
        int            got, en_at, exp_ack, n;
        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            checks++;
            if ({mem_en, cpu_ack, ldr_ack, owner_ldr} !== 4'b0) begin
                failures++; $display("FAIL rnd%0d_idle: got en%b acks%b%b own%b exp 0", it, mem_en, cpu_ack, ldr_ack, owner_ldr);
            end
            pc = ($urandom % 3) != 0;
            pl = ($urandom % 3) != 0;
            if (!pc && !pl) pc = 1'b1;
            c_we = 1'($urandom); c_addr = 12'($urandom_range(0, 7)) | (($urandom % 2) ? 12'hFF8 : 12'h000); c_wd = 16'($urandom);
            l_we = 1'($urandom); l_addr = 12'($urandom_range(0, 7)) | (($urandom % 2) ? 12'hFF8 : 12'h000); l_wd = 16'($urandom);
            cpu_req = pc; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
            ldr_req = pl; ldr_we = l_we; ldr_addr = l_addr; ldr_wdata = l_wd;
            first = (pc && pl) ? ~exp_last_ldr : pl;
            n = int'(pc) + int'(pl);
            for (int s = 0; s < n; s++) begin
                who    = (s == 0) ? first : ~first;
                t_we   = who ? l_we : c_we;
                t_addr = who ? l_addr : c_addr;
                t_wd   = who ? l_wd : c_wd;
                exp_ack = s + (t_we ? 2 : 3);
                got = -1; en_at = -1;
                for (int c = 1; c <= 7; c++) begin
                    @(negedge clk);
                    if (mem_en && en_at < 0) begin
                        en_at = c;
                        checks++;
                        if ({mem_we, mem_addr, owner_ldr} !== {t_we, t_addr, who} || (t_we && mem_wdata !== t_wd)) begin
                            failures++; $display("FAIL rnd%0d_bus: got we%b %h=%h own%b exp we%b %h=%h own%b", it, mem_we, mem_addr, mem_wdata, owner_ldr, t_we, t_addr, t_wd, who);
                        end
                        // late input changes by the owner must not matter
                        if (who) begin ldr_we = 1'($urandom); ldr_addr = 12'($urandom); ldr_wdata = 16'($urandom); end
                        else     begin cpu_we = 1'($urandom); cpu_addr = 12'($urandom); cpu_wdata = 16'($urandom); end
                    end
                    if (cpu_ack || ldr_ack) begin got = c; break; end
                end
                checks++;
                if (got != exp_ack || en_at != s + 1 || {ldr_ack, cpu_ack} !== (who ? 2'b10 : 2'b01)) begin
                    failures++; $display("FAIL rnd%0d_ack%0d: got ack at %0d en at %0d ldr%b cpu%b exp ack at %0d en at %0d owner %b", it, s, got, en_at, ldr_ack, cpu_ack, exp_ack, s + 1, who);
                end
                if (t_we) ref_mem[t_addr] = t_wd;
                else if (who) exp_ldr_rd = ref_mem[t_addr];
                else exp_cpu_rd = ref_mem[t_addr];
                exp_last_ldr = who;
                checks++;
                if ({cpu_rdata, ldr_rdata} !== {exp_cpu_rd, exp_ldr_rd}) begin
                    failures++; $display("FAIL rnd%0d_rdata%0d: got %h/%h exp %h/%h", it, s, cpu_rdata, ldr_rdata, exp_cpu_rd, exp_ldr_rd);
                end
                if (who) ldr_req = 1'b0; else cpu_req = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 16'(i * 7 + 3);
        model_reset();
        test_reset();
        test_cpu_write();
        test_cpu_read();
        test_contention();
        test_ldr_first();
        test_reset_mid_txn();
        test_req_drop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
